// File: rtl/coproc_pkg.sv
// -----------------------------------------------------------------------------
// coproc_pkg
// Shared types and defaults for the matrix coprocessor sequencer.
//   seq_state_t    : sequencer FSM states
//   addr_region_t  : RAM region selector used by the address generator
//   DEF_DATA_W     : default RAM word / element width
//   DEF_ADDR_W     : default RAM address width
//   DEF_MAX_DIM    : default largest legal matrix dimension N
//   HDR_OFS        : offset of the header word (holding N) from the base address
// -----------------------------------------------------------------------------
package coproc_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_MAX_DIM = 5;
  localparam int HDR_OFS     = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HDR,
    S_CHK,
    S_RD_A,
    S_RD_B,
    S_OP,
    S_WR,
    S_FIN
  } seq_state_t;

  typedef enum logic [1:0] {
    REG_HDR,
    REG_A,
    REG_B,
    REG_C
  } addr_region_t;

endpackage

// File: rtl/seq_addr_gen.sv
// -----------------------------------------------------------------------------
// seq_addr_gen
// Combinational RAM address generator for the matrix sequencer.
// Layout: header at base, A[k] at base+1+k, B[k] at base+1+nsq+k,
// C[k] at base+1+2*nsq+k. All arithmetic wraps at ADDR_W bits.
// Ports:
//   base   in  ADDR_W  address of the header word
//   nsq    in  ADDR_W  number of elements (N*N)
//   k      in  ADDR_W  element index
//   region in  2       region select (HDR/A/B/C)
//   addr   out ADDR_W  resulting RAM address
// -----------------------------------------------------------------------------
module seq_addr_gen
  import coproc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] nsq,
  input  logic [ADDR_W-1:0] k,
  input  addr_region_t      region,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] elem_base;

  // First element slot sits one word past the header.
  assign elem_base = base + ADDR_W'(1);

  always_comb begin
    addr = base + ADDR_W'(HDR_OFS);
    case (region)
      REG_HDR: addr = base + ADDR_W'(HDR_OFS);
      REG_A:   addr = elem_base + k;
      REG_B:   addr = elem_base + nsq + k;
      REG_C:   addr = elem_base + nsq + nsq + k;
      default: addr = base + ADDR_W'(HDR_OFS);
    endcase
  end

endmodule

// File: rtl/matrix_op_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_op_sequencer
// Sequences an element-wise matrix operation over a single-port RAM:
// reads N from the header, then for each element k reads A[k] and B[k],
// presents them to a combinational datapath and writes C[k] back.
//
// Optional feature (macro MATRIX_SEQ_PERF_EN): adds a 16-bit saturating
// cycle_count output counting busy cycles of the most recent run.
//
// Ports:
//   clk          in   1       system clock
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       run request, only honoured in IDLE
//   busy         out  1       run in progress (cycle after start .. done)
//   done         out  1       one-cycle end-of-run pulse
//   err          out  1       last run aborted on an illegal N
//   mem_addr     out  ADDR_W  RAM address
//   mem_wdata    out  DATA_W  RAM write data
//   mem_we       out  1       RAM write enable
//   mem_rdata    in   DATA_W  RAM read data (RD_LAT cycles after address)
//   op_a, op_b   out  DATA_W  operands to the datapath
//   op_valid     out  1       operands valid (OP state)
//   op_result    in   DATA_W  datapath result
//   cycle_count  out  16      busy-cycle counter (MATRIX_SEQ_PERF_EN only)
// -----------------------------------------------------------------------------
module matrix_op_sequencer
  import coproc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_DIM   = DEF_MAX_DIM,
  parameter int RD_LAT    = 1,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic [DATA_W-1:0] op_result
`ifdef MATRIX_SEQ_PERF_EN
  ,
  output logic [15:0]       cycle_count
`endif
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]        LAT  = 2'(RD_LAT);

  seq_state_t        state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] nsq_q, nsq_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  addr_region_t      region;
  logic [ADDR_W-1:0] n_ext;
  logic              n_illegal;

  assign n_ext     = ADDR_W'(n_q);
  assign n_illegal = (n_q == '0) || (n_q > DATA_W'(MAX_DIM));

  seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .base   (BASE),
    .nsq    (nsq_q),
    .k      (k_q),
    .region (region),
    .addr   (mem_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      n_q     <= '0;
      nsq_q   <= '0;
      k_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      n_q     <= n_d;
      nsq_q   <= nsq_d;
      k_q     <= k_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    n_d     = n_q;
    nsq_d   = nsq_q;
    k_d     = k_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    region  = REG_HDR;

    case (state_q)
      // The header address is already on the bus while idle, so the
      // header read effectively starts in the start cycle and RD_HDR
      // only needs RD_LAT cycles.
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_HDR;
          err_d   = 1'b0;
          wait_d  = '0;
        end
      end

      S_RD_HDR: begin
        if (wait_q == LAT - 2'd1) begin
          n_d     = mem_rdata;
          wait_d  = '0;
          state_d = S_CHK;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_CHK: begin
        if (n_illegal) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          nsq_d   = n_ext * n_ext;
          k_d     = '0;
          wait_d  = '0;
          state_d = S_RD_A;
        end
      end

      // Operand addresses are first issued on entry, so data arrives
      // RD_LAT cycles later, i.e. when wait_q reaches RD_LAT.
      S_RD_A: begin
        region = REG_A;
        if (wait_q == LAT) begin
          op_a_d  = mem_rdata;
          wait_d  = '0;
          state_d = S_RD_B;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_RD_B: begin
        region = REG_B;
        if (wait_q == LAT) begin
          op_b_d  = mem_rdata;
          wait_d  = '0;
          state_d = S_OP;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_OP: begin
        region  = REG_C;
        wdata_d = op_result;
        state_d = S_WR;
      end

      S_WR: begin
        region = REG_C;
        if (k_q == nsq_q - ADDR_W'(1)) begin
          state_d = S_FIN;
        end else begin
          k_d     = k_q + ADDR_W'(1);
          state_d = S_RD_A;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign err       = err_q;
  assign mem_we    = (state_q == S_WR);
  assign mem_wdata = wdata_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = (state_q == S_OP);

`ifdef MATRIX_SEQ_PERF_EN
  logic [15:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if ((state_q == S_IDLE) && start) begin
      count_d = '0;
    end else if ((state_q != S_IDLE) && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  assign cycle_count = count_q;
`endif

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_op_sequencer
// Two sequencer instances (RD_LAT=1 and RD_LAT=2), each with its own RAM
// model and an adder datapath. A per-cycle checker compares busy/done/err
// and every RAM write against a run-level model derived from the memory
// contents at start; directed tests add literal expectations.
// Define MATRIX_SEQ_PERF_EN to also check cycle_count.
// -----------------------------------------------------------------------------
module tb_matrix_op_sequencer;

  localparam int NI   = 2;
  localparam int BASE = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s  [NI];
  logic       busy_s   [NI];
  logic       done_s   [NI];
  logic       err_s    [NI];
  logic       we_s     [NI];
  logic       opv_s    [NI];
  logic [7:0] addr_s   [NI];
  logic [7:0] wdata_s  [NI];
  logic [7:0] rdata_s  [NI];
  logic [7:0] opa_s    [NI];
  logic [7:0] opb_s    [NI];
  logic [7:0] res_s    [NI];
`ifdef MATRIX_SEQ_PERF_EN
  logic [15:0] cc_s    [NI];
`endif

  logic [7:0] mem [NI][256];

  int checks   = 0;
  int failures = 0;

  // Run-level model state and observation records (written by checker only)
  bit         m_active [NI];
  int         m_cyc    [NI];
  int         m_lat    [NI];
  bit         m_runerr [NI];
  bit         m_err    [NI];
  int         m_nw     [NI];
  int         m_wi     [NI];
  int         m_waddr  [NI][32];
  int         m_wdata  [NI][32];
  int         done_cnt [NI];
  int         last_lat [NI];
  int         wr_total [NI];
  logic [7:0] wlog     [NI][256];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = gi + 1;
    logic [7:0] pipe [LAT];

    always @(posedge clk) begin
      pipe[0] <= mem[gi][addr_s[gi]];
      for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign rdata_s[gi] = pipe[LAT-1];
    assign res_s[gi]   = opa_s[gi] + opb_s[gi];

    matrix_op_sequencer #(
      .DATA_W    (8),
      .ADDR_W    (8),
      .MAX_DIM   (5),
      .RD_LAT    (LAT),
      .BASE_ADDR (BASE)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_s[gi]),
      .busy      (busy_s[gi]),
      .done      (done_s[gi]),
      .err       (err_s[gi]),
      .mem_addr  (addr_s[gi]),
      .mem_wdata (wdata_s[gi]),
      .mem_we    (we_s[gi]),
      .mem_rdata (rdata_s[gi]),
      .op_a      (opa_s[gi]),
      .op_b      (opb_s[gi]),
      .op_valid  (opv_s[gi]),
      .op_result (res_s[gi])
`ifdef MATRIX_SEQ_PERF_EN
      ,
      .cycle_count (cc_s[gi])
`endif
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle checker and model
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst_busy%0d", i), 32'(busy_s[i]), 0);
        chk($sformatf("rst_we%0d", i), 32'(we_s[i]), 0);
        chk($sformatf("rst_done%0d", i), 32'(done_s[i]), 0);
        chk($sformatf("rst_err%0d", i), 32'(err_s[i]), 0);
        m_active[i] = 1'b0;
        m_err[i]    = 1'b0;
      end else begin
        if (m_active[i]) begin
          m_cyc[i]++;
          if (m_cyc[i] == 1) m_err[i] = 1'b0;
          if (m_cyc[i] == m_lat[i]) m_err[i] = m_runerr[i];
        end
        chk($sformatf("busy%0d", i), 32'(busy_s[i]), 32'(m_active[i]));
        chk($sformatf("done%0d", i), 32'(done_s[i]),
            32'(m_active[i] && (m_cyc[i] == m_lat[i])));
        chk($sformatf("err%0d", i), 32'(err_s[i]), 32'(m_err[i]));

        if (we_s[i] === 1'b1) begin
          if (m_active[i] && (m_wi[i] < m_nw[i])) begin
            chk($sformatf("waddr%0d", i), 32'(addr_s[i]), 32'(m_waddr[i][m_wi[i]]));
            chk($sformatf("wdata%0d", i), 32'(wdata_s[i]), 32'(m_wdata[i][m_wi[i]]));
          end else begin
            chk($sformatf("unexpected_write%0d", i), 32'(m_wi[i]), 32'(m_nw[i]) + 32'd1000);
          end
          m_wi[i]++;
          wr_total[i]++;
          wlog[i][addr_s[i]] = wdata_s[i];
        end

        if (done_s[i] === 1'b1) begin
          done_cnt[i]++;
          last_lat[i] = m_active[i] ? m_cyc[i] : -1;
        end

        if (m_active[i]) begin
          if (m_cyc[i] == m_lat[i]) begin
            chk($sformatf("write_count%0d", i), 32'(m_wi[i]), 32'(m_nw[i]));
            m_active[i] = 1'b0;
          end
        end else if (start_s[i] === 1'b1) begin
          int n, nsq, rl;
          n   = int'(mem[i][BASE]);
          rl  = i + 1;
          nsq = n * n;
          if (n >= 1 && n <= 5) begin
            m_runerr[i] = 1'b0;
            m_lat[i]    = 2 + rl + nsq * (2 * rl + 4);
            m_nw[i]     = nsq;
            for (int k = 0; k < nsq; k++) begin
              m_waddr[i][k] = BASE + 1 + 2 * nsq + k;
              m_wdata[i][k] = (int'(mem[i][BASE+1+k]) + int'(mem[i][BASE+1+nsq+k])) % 256;
            end
          end else begin
            m_runerr[i] = 1'b1;
            m_lat[i]    = 2 + rl;
            m_nw[i]     = 0;
          end
          m_wi[i]     = 0;
          m_cyc[i]    = 0;
          wr_total[i] = 0;
          m_active[i] = 1'b1;
        end
      end
    end
  end

  task automatic load(input int i, input int n, input int ma, input int mb);
    mem[i][BASE] = 8'(n);
    for (int k = 0; k < n * n; k++) begin
      mem[i][BASE+1+k]       = 8'(ma * (k + 1));
      mem[i][BASE+1+n*n+k]   = 8'(mb * (k + 1));
    end
  endtask

  task automatic run_to_done(input int i, input int budget);
    int d0;
    int cnt;
    d0 = done_cnt[i];
    @(posedge clk); #1 start_s[i] = 1'b1;
    @(posedge clk); #1 start_s[i] = 1'b0;
    cnt = 0;
    while (done_cnt[i] == d0 && cnt < budget) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    chk("done_seen", 32'(done_cnt[i] - d0), 1);
  endtask

  task automatic chk_reset_outputs(input int i);
    chk("async_busy", 32'(busy_s[i]), 0);
    chk("async_done", 32'(done_s[i]), 0);
    chk("async_err", 32'(err_s[i]), 0);
    chk("async_we", 32'(we_s[i]), 0);
    chk("async_addr", 32'(addr_s[i]), BASE);
    chk("async_wdata", 32'(wdata_s[i]), 0);
    chk("async_opa", 32'(opa_s[i]), 0);
    chk("async_opb", 32'(opb_s[i]), 0);
    chk("async_opvalid", 32'(opv_s[i]), 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_s[i]  = 1'b0;
      done_cnt[i] = 0;
      wr_total[i] = 0;
      last_lat[i] = 0;
      for (int a = 0; a < 256; a++) begin
        mem[i][a]  = 8'hEE;
        wlog[i][a] = 8'h00;
      end
    end

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
`ifdef MATRIX_SEQ_PERF_EN
    chk("rst_cycle_count", 32'(cc_s[0]), 0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Scenario 1: N=2 add, RD_LAT=1
    load(0, 2, 1, 10);
    run_to_done(0, 100);
    $display("T1 N=2 lat=%0d writes=%0d", last_lat[0], wr_total[0]);
    chk("t1_latency", 32'(last_lat[0]), 27);
    chk("t1_writes", 32'(wr_total[0]), 4);
    chk("t1_c0", 32'(wlog[0][9]), 11);
    chk("t1_c1", 32'(wlog[0][10]), 22);
    chk("t1_c2", 32'(wlog[0][11]), 33);
    chk("t1_c3", 32'(wlog[0][12]), 44);
    chk("t1_err", 32'(err_s[0]), 0);
`ifdef MATRIX_SEQ_PERF_EN
    repeat (5) @(posedge clk);
    #1;
    chk("t6_cycle_count_held", 32'(cc_s[0]), 27);
`endif

    // Scenario 2: illegal N (0 and 6)
    mem[0][BASE] = 8'd0;
    run_to_done(0, 50);
    $display("T2 N=0 lat=%0d writes=%0d err=%0b", last_lat[0], wr_total[0], err_s[0]);
    chk("t2_n0_latency", 32'(last_lat[0]), 3);
    chk("t2_n0_writes", 32'(wr_total[0]), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_n0_err_held", 32'(err_s[0]), 1);
    mem[0][BASE] = 8'd6;
    run_to_done(0, 50);
    $display("T2 N=6 lat=%0d writes=%0d err=%0b", last_lat[0], wr_total[0], err_s[0]);
    chk("t2_n6_latency", 32'(last_lat[0]), 3);
    chk("t2_n6_writes", 32'(wr_total[0]), 0);
    chk("t2_n6_err", 32'(err_s[0]), 1);

    // Scenario 3: N=5, RD_LAT=2 (second instance)
    load(1, 5, 1, 10);
    run_to_done(1, 400);
    $display("T3 N=5 lat=%0d writes=%0d", last_lat[1], wr_total[1]);
    chk("t3_latency", 32'(last_lat[1]), 204);
    chk("t3_writes", 32'(wr_total[1]), 25);
    chk("t3_c_first", 32'(wlog[1][51]), 11);
    chk("t3_c_mid", 32'(wlog[1][63]), 143);
    chk("t3_c_last_wrap", 32'(wlog[1][75]), 19);

    // Scenario 4: stray starts mid-run and in FIN
    load(0, 2, 1, 10);
    d0 = done_cnt[0];
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
`ifdef MATRIX_SEQ_PERF_EN
    chk("t4_cycle_count_cleared", 32'(cc_s[0]), 0);
`endif
    repeat (2) @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (6) @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (16) @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("T4 dones=%0d lat=%0d busy=%0b", done_cnt[0] - d0, last_lat[0], busy_s[0]);
    chk("t4_one_done", 32'(done_cnt[0] - d0), 1);
    chk("t4_latency", 32'(last_lat[0]), 27);
    chk("t4_idle_after", 32'(busy_s[0]), 0);

    // Scenario 5: reset mid-run at element 1, then a fresh run
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("T5 reset mid-run writes_before=%0d", wr_total[0]);
    chk_reset_outputs(0);
    chk("t5_writes_before_reset", 32'(wr_total[0]), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    load(0, 2, 3, 7);
    run_to_done(0, 100);
    $display("T5 fresh run lat=%0d writes=%0d", last_lat[0], wr_total[0]);
    chk("t5_latency", 32'(last_lat[0]), 27);
    chk("t5_writes", 32'(wr_total[0]), 4);
    chk("t5_c0", 32'(wlog[0][9]), 10);
    chk("t5_c3", 32'(wlog[0][12]), 40);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
